// File: rtl/axicb_mst_ooo_tracker_if.sv
// Request/completion bundle between the crossbar routing logic and the
// slave-side outstanding-request tracker.
interface axicb_mst_ooo_tracker_if #(
    parameter int AXI_ID_W = 8,
    parameter int MST_NB   = 4
);
    // Address request side
    logic                a_valid;
    logic                a_ready;
    logic                a_full;
    logic [AXI_ID_W-1:0] a_id;
    logic [7:0]          a_len;
    logic [MST_NB-1:0]   a_mst;

    // Completion side
    logic                c_valid;
    logic                c_ready;
    logic [AXI_ID_W-1:0] c_id;
    logic                c_last;
    logic [MST_NB-1:0]   c_grant;
    logic [MST_NB-1:0]   m_ready;
    logic                c_unexp;
    logic                c_lenerr;

    // Driver of requests/completions (crossbar side)
    modport master (
        output a_valid, a_id, a_len, a_mst,
        output c_valid, c_id, c_last, m_ready,
        input  a_ready, a_full, c_ready, c_grant, c_unexp, c_lenerr
    );

    // The tracker itself
    modport slave (
        input  a_valid, a_id, a_len, a_mst,
        input  c_valid, c_id, c_last, m_ready,
        output a_ready, a_full, c_ready, c_grant, c_unexp, c_lenerr
    );
endinterface

// File: rtl/axicb_mst_ooo_tracker.sv
// Slave-side outstanding-request tracker: remembers which master issued each
// accepted request (binned by ID, in order within a bin) and steers every
// completion beat back to that master as a one-hot grant. Completions with no
// matching request and bursts with a wrong beat count are flagged.
module axicb_mst_ooo_tracker #(
    parameter int AXI_ID_W        = 8,
    parameter int MST_NB          = 4,
    parameter int SLV_OSTDREQ_NUM = 4,
    parameter int ID_BINS         = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    axicb_mst_ooo_tracker_if.slave bus
);
    localparam int BIN_W = $clog2(ID_BINS);
    localparam int PTR_W = $clog2(SLV_OSTDREQ_NUM);
    localparam int ENT_W = 8 + MST_NB;

    logic [BIN_W-1:0]   a_bin;
    logic [BIN_W-1:0]   c_bin;
    logic [ID_BINS-1:0] bin_full;
    logic [ID_BINS-1:0] bin_empty;
    logic [ENT_W-1:0]   head_ent [ID_BINS];
    logic [7:0]         cnt_bin  [ID_BINS];

    logic               push_en;
    logic               c_empty;
    logic [7:0]         head_len;
    logic [MST_NB-1:0]  head_mst;
    logic [7:0]         c_cnt;
    logic [MST_NB-1:0]  c_grant;
    logic               c_ready;
    logic               c_hs;
    logic               unexp_next;
    logic               lenerr_next;
    logic               unexp_reg;
    logic               lenerr_reg;

    // Only the low ID bits select a bin; the rest are deliberately ignored.
    logic               unused_id_bits;
    assign unused_id_bits = ^{bus.a_id, bus.c_id};

    assign a_bin = bus.a_id[BIN_W-1:0];
    assign c_bin = bus.c_id[BIN_W-1:0];

    // Acceptance depends only on the registered full flag of the target bin,
    // so a bin that pops this cycle still refuses a push until next cycle.
    assign bus.a_ready = !bin_full[a_bin];
    assign bus.a_full  = &bin_full;
    assign push_en     = bus.a_valid && !bin_full[a_bin];

    assign c_empty  = bin_empty[c_bin];
    assign head_len = head_ent[c_bin][ENT_W-1:MST_NB];
    assign head_mst = head_ent[c_bin][MST_NB-1:0];
    assign c_cnt    = cnt_bin[c_bin];

    // Completion routing: grant to the head master, or drain silently when
    // nothing is outstanding for this bin.
    always_comb begin
        c_grant = '0;
        c_ready = 1'b0;
        if (bus.c_valid) begin
            if (c_empty) begin
                c_ready = 1'b1;
            end else begin
                c_grant = head_mst;
                c_ready = |(head_mst & bus.m_ready);
            end
        end
    end

    assign bus.c_grant = c_grant;
    assign bus.c_ready = c_ready;

    // A tracked beat transfer (drained unexpected beats excluded).
    assign c_hs        = bus.c_valid && c_ready && !c_empty;
    assign unexp_next  = bus.c_valid && c_empty;
    assign lenerr_next = c_hs && (bus.c_last ? (c_cnt != head_len)
                                             : (c_cnt == head_len));

    // Error pulses are registered so they appear one cycle after the beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            unexp_reg  <= 1'b0;
            lenerr_reg <= 1'b0;
        end else if (srst) begin
            unexp_reg  <= 1'b0;
            lenerr_reg <= 1'b0;
        end else begin
            unexp_reg  <= unexp_next;
            lenerr_reg <= lenerr_next;
        end
    end

    assign bus.c_unexp  = unexp_reg;
    assign bus.c_lenerr = lenerr_reg;

    // One in-order FIFO plus beat counter per ID bin.
    generate
        for (genvar gi = 0; gi < ID_BINS; gi++) begin : g_bin
            logic [PTR_W:0]   wr_ptr_reg;
            logic [PTR_W:0]   rd_ptr_reg;
            logic [7:0]       cnt_reg;
            logic [ENT_W-1:0] mem_reg [SLV_OSTDREQ_NUM];
            logic             push_here;
            logic             hs_here;
            logic             pop_here;

            assign push_here = push_en && (a_bin == BIN_W'(gi));
            assign hs_here   = c_hs && (c_bin == BIN_W'(gi));
            assign pop_here  = hs_here && bus.c_last;

            // Extra pointer MSB tells full (MSBs differ) from empty (equal).
            assign bin_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign bin_full[gi]  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
            assign head_ent[gi]  = mem_reg[rd_ptr_reg[PTR_W-1:0]];
            assign cnt_bin[gi]   = cnt_reg;

            // Pointer update; push and pop in the same cycle both take effect.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else if (srst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push_here) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop_here)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end

            // Beat counter: clears on the last beat, saturates at 255 otherwise.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    cnt_reg <= '0;
                end else if (srst) begin
                    cnt_reg <= '0;
                end else if (pop_here) begin
                    cnt_reg <= '0;
                end else if (hs_here && cnt_reg != 8'hFF) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end

            // Entry storage; contents are only meaningful while not empty.
            always_ff @(posedge aclk) begin
                if (push_here) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= {bus.a_len, bus.a_mst};
            end
        end
    endgenerate
endmodule

// File: doc/axicb_mst_ooo_tracker.md
Name: axicb_mst_ooo_tracker

Overview:
- Slave-port-side outstanding-request tracker for the crossbar; the responder-end counterpart of the master-side ID/ordering logic.
- Records which master issued each accepted address request, binned by AXI ID and kept in order within each bin.
- Routes each completion beat (read or write response) returned by the slave back to the originating master as a one-hot grant.
- Flags completions with no matching outstanding request, and bursts whose beat count disagrees with the recorded length.

Parameters:
- AXI_ID_W, 8, ID width in bits.
- MST_NB, 4, number of masters (width of the one-hot master index).
- SLV_OSTDREQ_NUM, 4, maximum outstanding requests per ID bin; power of 2, at least 2.
- ID_BINS, 4, number of tracked ID bins; power of 2, at most 2**AXI_ID_W. Bin = a_id[$clog2(ID_BINS)-1:0].

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset
- a_valid  in  1  address request valid, already routed to this slave
- a_ready  out  1  request accepted: target bin not full
- a_full  out  1  all bins full
- a_id  in  AXI_ID_W  request ID
- a_len  in  8  AXI burst length (beats-1); write channel drives 0
- a_mst  in  MST_NB  one-hot issuing master
- c_valid  in  1  completion beat valid from slave
- c_ready  out  1  completion beat accepted
- c_id  in  AXI_ID_W  completion ID
- c_last  in  1  last beat of the completion (tie 1 for write responses)
- c_grant  out  MST_NB  one-hot master receiving the current beat
- m_ready  in  MST_NB  per-master completion ready
- c_unexp  out  1  one-cycle pulse: unexpected completion drained
- c_lenerr  out  1  one-cycle pulse: burst length mismatch

Behaviour:
- Storage: per bin, one FIFO of depth SLV_OSTDREQ_NUM holding {a_len, a_mst}, plus one 8-bit beat counter.
- Push: a_valid && a_ready. a_ready = !full[bin(a_id)], combinational, independent of a_valid. a_full = AND of all bin full flags.
- Latency: a pushed entry becomes visible to the completion side on the next cycle. A completion arriving in the push cycle for a previously empty bin is treated as unexpected.
- Grant, bin b = bin(c_id) not empty: c_grant = head(b).mst when c_valid, else 0. c_ready = |(c_grant & m_ready).
- Beat handshake = c_valid && c_ready.
  - On a handshake with !c_last: counter[b] increments.
  - On a handshake with c_last: FIFO b pops and counter[b] clears to 0.
- Length error: c_lenerr pulses on the cycle after a handshake where either
  - c_last=1 and counter != head.len, or
  - c_last=0 and counter == head.len.
  - Routing is unaffected; the pop still happens only on c_last. The counter saturates at 255.
- Unexpected completion, bin b empty and c_valid: c_grant = 0, c_ready = 1 (beat is drained), c_unexp pulses on the following cycle, counter untouched.
- Simultaneous push and pop on the same bin are both performed. A full bin stays a_ready=0 that cycle, because ready derives from the registered full flag. Pop-then-push ordering is preserved.
- Different bins operate independently; beats of different IDs may interleave freely, and each bin keeps its own counter.
- Pointers wrap modulo SLV_OSTDREQ_NUM. An extra occupancy bit distinguishes full from empty.
- Reset values (aresetn low, async; srst high, sync; identical result):
  - all FIFOs empty, all counters 0
  - a_ready=1, a_full=0
  - c_grant=0, c_ready=0
  - c_unexp=0, c_lenerr=0
- Reset mid-burst discards every outstanding entry. Any later completion for those entries is reported as unexpected.
- c_grant and c_ready are combinational from registered state plus c_valid, c_id and m_ready. No combinational path from a_* to c_*.

Test Plan:
- Reset, then push id=0 len=3 mst=4'b0010; return 4 beats with c_last on the 4th and m_ready=all-1 → c_grant=4'b0010 on every beat, bin 0 empty afterwards, no error pulses.
- Push 4 requests to id=1 (mst 0001,0010,0100,1000) → a_ready=0 on the 5th id=1 push while an id=2 push is accepted. Complete the 4 in order → grants follow in issue order.
- Interleave beats of id=0 (len=1, mst 0001) and id=3 (len=2, mst 1000) → each beat granted to its own master, both bins empty at the end.
- c_valid with id=2 and bin 2 empty → c_ready=1, c_grant=0, c_unexp=1 exactly one cycle later.
- Push id=0 len=3, return c_last on the 2nd beat → c_lenerr pulse, entry popped. m_ready=0 on the granted master → c_ready=0, and the counter holds.
- Assert aresetn low with 3 entries outstanding → a_full=0, a_ready=1, c_grant=0. A following completion → c_unexp.
